// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - press/release/long-press event pulses, held level and press counter
// Optional double-click detection is compiled in with BTN_DOUBLE_CLICK_EN.
`timescale 1ns/1ps

module btn_event_decoder #(
  parameter int LONG_CYCLES = 100,
  parameter int CNT_W       = 8,
  parameter int DBL_CYCLES  = 50
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             but_i,
  output logic             press_o,
  output logic             release_o,
  output logic             long_o,
  output logic             held_o,
  output logic [CNT_W-1:0] count_o,
  output logic             dbl_o
);

  localparam int HW = $clog2(LONG_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  state_t           state_q, state_d;
  logic             prev_q;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rising;

  assign rising = but_i & ~prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      prev_q     <= 1'b0;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= but_i;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      held_q     <= held_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    held_d     = held_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (rising) begin
          press_d    = 1'b1;
          held_d     = 1'b1;
          count_d    = count_q + CNT_W'(1);
          hold_cnt_d = HW'(1);
          state_d    = PRESSED;
        end
      end
      PRESSED: begin
        if (but_i) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
          // hold_cnt already counts this press's earlier high samples, so this is the LONG_CYCLES-th
          if (hold_cnt_q == HW'(LONG_CYCLES - 1)) begin
            long_d  = 1'b1;
            state_d = LONG_HELD;
          end
        end else begin
          release_d  = 1'b1;
          held_d     = 1'b0;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      LONG_HELD: begin
        if (!but_i) begin
          release_d  = 1'b1;
          held_d     = 1'b0;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
        held_d     = 1'b0;
      end
    endcase
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign held_o    = held_q;
  assign count_o   = count_q;

`ifdef BTN_DOUBLE_CLICK_EN
  localparam int GW = $clog2(DBL_CYCLES + 1);

  logic          armed_q, armed_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          dbl_q, dbl_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      armed_q   <= 1'b0;
      gap_cnt_q <= '0;
      dbl_q     <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      gap_cnt_q <= gap_cnt_d;
      dbl_q     <= dbl_d;
    end
  end

  always_comb begin
    armed_d   = armed_q;
    gap_cnt_d = gap_cnt_q;
    dbl_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q) begin
          if (rising) begin
            dbl_d   = (gap_cnt_q < GW'(DBL_CYCLES));
            armed_d = 1'b0;
          end else if (gap_cnt_q == GW'(DBL_CYCLES)) begin
            armed_d = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end
      PRESSED: begin
        if (!but_i) begin
          armed_d   = 1'b1;
          gap_cnt_d = '0;
        end
      end
      LONG_HELD: begin
        if (!but_i) armed_d = 1'b0;
      end
      default: armed_d = 1'b0;
    endcase
  end

  assign dbl_o = dbl_q;
`else
  // Always 0 for any legal DBL_CYCLES; keeps the parameter referenced in this build.
  assign dbl_o = (DBL_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - scoreboard bench for btn_event_decoder
// Expected dbl_o behaviour follows BTN_DOUBLE_CLICK_EN.
`timescale 1ns/1ps

module tb_btn_event_decoder;

  localparam int LONG = 8;
  localparam int CW   = 3;
  localparam int DBL  = 5;
`ifdef BTN_DOUBLE_CLICK_EN
  localparam int DBL_ON = 1;
`else
  localparam int DBL_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          but_i = 1'b0;
  logic          press_o, release_o, long_o, held_o, dbl_o;
  logic [CW-1:0] count_o;

  btn_event_decoder #(.LONG_CYCLES(LONG), .CNT_W(CW), .DBL_CYCLES(DBL)) dut (
    .clk(clk), .rstn(rstn), .but_i(but_i),
    .press_o(press_o), .release_o(release_o), .long_o(long_o),
    .held_o(held_o), .count_o(count_o), .dbl_o(dbl_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          press;
    logic          rel;
    logic          lng;
    logic          held;
    logic          dbl;
    logic [CW-1:0] count;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_press, n_rel, n_long, n_dbl, n_held;

  int m_prev, m_pressed, m_run, m_count, m_armed, m_gap, m_held;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic b, input logic r, output exp_t e);
    e = '0;
    if (!r) begin
      m_prev = 0; m_pressed = 0; m_run = 0; m_count = 0;
      m_armed = 0; m_gap = 0; m_held = 0;
    end else begin
      if (!m_pressed) begin
        if (b && !m_prev) begin
          e.press = 1'b1;
          m_pressed = 1; m_run = 1; m_held = 1;
          m_count = (m_count + 1) % (1 << CW);
          if (DBL_ON != 0 && m_armed != 0 && m_gap < DBL) e.dbl = 1'b1;
          m_armed = 0;
        end else if (m_armed != 0 && m_gap < DBL) begin
          m_gap++;
        end
      end else if (b) begin
        m_run++;
        if (m_run == LONG) e.lng = 1'b1;
      end else begin
        e.rel = 1'b1;
        m_pressed = 0; m_held = 0;
        m_armed = (m_run < LONG) ? 1 : 0;
        m_gap = 0; m_run = 0;
      end
      m_prev = b ? 1 : 0;
    end
    e.held  = (m_held != 0);
    e.count = m_count[CW-1:0];
  endtask

  task automatic step(input logic b, input logic r);
    exp_t e;
    but_i = b;
    rstn  = r;
    model(b, r, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("press_o",   8'(press_o),   8'(e.press));
    chk("release_o", 8'(release_o), 8'(e.rel));
    chk("long_o",    8'(long_o),    8'(e.lng));
    chk("held_o",    8'(held_o),    8'(e.held));
    chk("dbl_o",     8'(dbl_o),     8'(e.dbl));
    chk("count_o",   8'(count_o),   8'(e.count));
    n_press += int'(press_o);
    n_rel   += int'(release_o);
    n_long  += int'(long_o);
    n_dbl   += int'(dbl_o);
    n_held  += int'(held_o);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic clr_tally();
    n_press = 0; n_rel = 0; n_long = 0; n_dbl = 0; n_held = 0;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    low(1);
    clr_tally();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_tally();
    // reset with toggling input
    for (int i = 0; i < 5; i++) step(1'(i & 1), 1'b0);
    chk("rst_count", 8'(count_o), 8'd0);
    chk("rst_held",  8'(held_o),  8'd0);
    low(2);
    hold(3);
    clr_tally();
    step(1'b1, 1'b0);
    chk("midrst_held", 8'(held_o), 8'd0);
    low(2);
    chk("midrst_no_release", 8'(n_rel), 8'd0);
    // button held across reset release counts as a new press
    step(1'b1, 1'b0);
    clr_tally();
    hold(2);
    low(2);
    chk("held_thru_rst_press", 8'(n_press), 8'd1);

    do_reset();
    hold(3);
    low(2);
    chk("short_press", 8'(n_press), 8'd1);
    chk("short_rel",   8'(n_rel),   8'd1);
    chk("short_long",  8'(n_long),  8'd0);
    chk("short_held",  8'(n_held),  8'd3);
    chk("short_count", 8'(count_o), 8'd1);

    do_reset();
    hold(20);
    chk("long_pulses", 8'(n_long), 8'd1);
    chk("long_held",   8'(n_held), 8'd20);
    low(2);
    chk("long_rel",    8'(n_rel),  8'd1);
    chk("long_count",  8'(count_o), 8'd1);

    do_reset();
    hold(7);
    low(2);
    chk("hold7_long", 8'(n_long), 8'd0);
    clr_tally();
    hold(8);
    chk("hold8_long", 8'(long_o), 8'd1);
    low(1);
    chk("hold8_rel_next", 8'(release_o), 8'd1);
    low(1);
    chk("hold8_long_cnt", 8'(n_long), 8'd1);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      hold(1);
      chk("wrap_count", 8'(count_o), 8'((i + 1) % 8));
      low(2);
    end

    do_reset();
    hold(2);
    low(3);
    hold(1);
    chk("dbl_quick", 8'(n_dbl), 8'(DBL_ON));
    chk("dbl_with_press", 8'(dbl_o & press_o), 8'(DBL_ON));
    low(10);
    clr_tally();
    hold(2);
    low(6);
    hold(1);
    chk("dbl_late", 8'(n_dbl), 8'd0);
    low(10);
    clr_tally();
    hold(10);
    low(2);
    hold(1);
    low(2);
    chk("dbl_after_long", 8'(n_dbl), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
